// File: rtl/bcd_conv_hs.sv
// Handshaked binary-to-BCD converter using double-dabble, one add-3/shift step per clock.
// Optional two's-complement input yields sign + magnitude; sticky overflow and digit count.
`timescale 1ns/1ps
module bcd_conv_hs #(
  parameter int unsigned LEN    = 8,
  parameter int unsigned DIGITS = 3,
  parameter bit          SIGNED = 1'b0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [LEN-1:0]                 in_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [4*DIGITS-1:0]            out_bcd,
  output logic                           out_neg,
  output logic                           out_ovfl,
  output logic [$clog2(DIGITS+1)-1:0]    out_ndig
);

  localparam int unsigned CW = $clog2(LEN + 1);
  localparam int unsigned BW = 4 * DIGITS;
  localparam int unsigned NW = $clog2(DIGITS + 1);
  localparam logic [CW-1:0] CtrLast = CW'(LEN - 1);

  typedef enum logic [1:0] {StIdle, StConv, StDone} state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  ctr_q, ctr_d;
  logic [LEN-1:0] bin_q, bin_d;
  logic [BW-1:0]  bcd_q, bcd_d;
  logic           neg_q, neg_d;
  logic           ovfl_q, ovfl_d;

  logic [BW-1:0]  adj;
  logic [BW-1:0]  step_bcd;
  logic           step_out;
  logic [NW-1:0]  ndig;
  logic           in_neg;
  logic [LEN-1:0] mag;
  logic           load_out;

  assign in_neg = SIGNED && in_data[LEN-1];
  // -(-2**(LEN-1)) wraps to 2**(LEN-1), which is the correct unsigned magnitude
  assign mag    = in_neg ? (~in_data + LEN'(1)) : in_data;

  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    {step_out, step_bcd} = {adj, bin_q[LEN-1]};
  end

  // Digit count of the value about to be loaded (result of the final step)
  always_comb begin
    ndig = NW'(1);
    for (int i = 1; i < DIGITS; i++) begin
      if (step_bcd[4*i +: 4] != 4'd0) ndig = NW'(i + 1);
    end
    if (ovfl_q | step_out) ndig = NW'(DIGITS);
  end

  always_comb begin
    state_d  = state_q;
    ctr_d    = ctr_q;
    bin_d    = bin_q;
    bcd_d    = bcd_q;
    neg_d    = neg_q;
    ovfl_d   = ovfl_q;
    in_ready = 1'b0;
    load_out = 1'b0;
    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) begin
          bin_d   = mag;
          neg_d   = in_neg;
          bcd_d   = '0;
          ovfl_d  = 1'b0;
          ctr_d   = '0;
          state_d = StConv;
        end
      end
      StConv: begin
        bin_d  = bin_q << 1;
        bcd_d  = step_bcd;
        ovfl_d = ovfl_q | step_out;
        ctr_d  = ctr_q + CW'(1);
        if (ctr_q == CtrLast) begin
          state_d  = StDone;
          load_out = 1'b1;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign out_valid = (state_q == StDone);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      ctr_q    <= '0;
      bin_q    <= '0;
      bcd_q    <= '0;
      neg_q    <= 1'b0;
      ovfl_q   <= 1'b0;
      out_bcd  <= '0;
      out_neg  <= 1'b0;
      out_ovfl <= 1'b0;
      out_ndig <= '0;
    end else begin
      state_q <= state_d;
      ctr_q   <= ctr_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      neg_q   <= neg_d;
      ovfl_q  <= ovfl_d;
      if (load_out) begin
        out_bcd  <= step_bcd;
        out_neg  <= neg_q;
        out_ovfl <= ovfl_q | step_out;
        out_ndig <= ndig;
      end
    end
  end

endmodule

// File: tb/tb_bcd_conv_hs.sv
// Scoreboard bench: several converter configurations driven with directed, exhaustive and
// random values; expected results come from an integer divide/modulo reference model.
`timescale 1ns/1ps
module tb_bcd_conv_hs;

  localparam int NCFG = 5;

  function automatic int cfg_len(input int g);
    return (g < 3) ? 8 : 10;
  endfunction

  function automatic int cfg_dig(input int g);
    case (g)
      1:       return 2;
      4:       return 4;
      default: return 3;
    endcase
  endfunction

  function automatic bit cfg_sgn(input int g);
    return (g == 2 || g == 4);
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;
  bit done [NCFG];

  task automatic chk(input int g, input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL cfg%0d %s: got 0x%0h, want 0x%0h", g, nm, act, exp);
    end
  endtask

  for (genvar g = 0; g < NCFG; g++) begin : gen_cfg
    localparam int L  = cfg_len(g);
    localparam int D  = cfg_dig(g);
    localparam bit S  = cfg_sgn(g);
    localparam int NW = $clog2(D + 1);

    typedef struct {
      longint bcd;
      bit     neg;
      bit     ovfl;
      int     ndig;
      int     acc;
    } exp_t;

    logic           rst, in_valid, in_ready, out_valid, out_ready, out_neg, out_ovfl;
    logic [L-1:0]   in_data;
    logic [4*D-1:0] out_bcd;
    logic [NW-1:0]  out_ndig;
    exp_t           q[$];

    bcd_conv_hs #(
      .LEN   (L),
      .DIGITS(D),
      .SIGNED(S)
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_bcd  (out_bcd),
      .out_neg  (out_neg),
      .out_ovfl (out_ovfl),
      .out_ndig (out_ndig)
    );

    function automatic exp_t model(input logic [L-1:0] v, input int acc);
      exp_t   e;
      longint mag, lim, t;
      e.acc = acc;
      e.neg = S && v[L-1];
      mag   = e.neg ? ((longint'(1) << L) - longint'(v)) : longint'(v);
      lim   = 1;
      for (int i = 0; i < D; i++) lim = lim * 10;
      e.ovfl = (mag >= lim);
      e.bcd  = 0;
      e.ndig = 1;
      t      = mag;
      for (int i = 0; i < D; i++) begin
        if (t % 10 != 0) e.ndig = i + 1;
        e.bcd = e.bcd | ((t % 10) << (4 * i));
        t = t / 10;
      end
      if (e.ovfl) e.ndig = D;
      return e;
    endfunction

    // Junk in_valid pulses while busy must be ignored
    task automatic wait_idle();
      int guard = 0;
      while (!in_ready && guard < 500) begin
        in_valid = ($urandom_range(0, 3) == 0);
        in_data  = L'($urandom);
        @(posedge clk); #1;
        guard++;
      end
      in_valid = 1'b0;
      chk(g, "idle_reached", in_ready, 1);
    endtask

    task automatic send(input logic [L-1:0] v);
      wait_idle();
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = v;
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_data  = L'($urandom);
    endtask

    initial begin : drv
      int dir [6] = '{255, 200, 99, 128, 255, 0};
      rst      = 1'b1;
      in_valid = 1'b0;
      in_data  = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      foreach (dir[k]) send(L'(dir[k]));
      // Abort a conversion in flight, then carry on
      wait_idle();
      in_valid = 1'b1;
      in_data  = L'(123);
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      if (L <= 8) begin
        for (int v = 0; v < (1 << L); v++) send(L'(v));
      end else begin
        repeat (300) send(L'($urandom));
      end
      for (int i = 0; i < 400 && (q.size() != 0 || out_valid); i++) begin
        @(posedge clk); #1;
      end
      chk(g, "drained", q.size(), 0);
      done[g] = 1'b1;
    end

    initial begin : rdy
      int hold = 0;
      out_ready = 1'b0;
      forever begin
        @(posedge clk); #1;
        if (hold > 0) begin
          hold--;
          out_ready = 1'b0;
        end else if ($urandom_range(0, 15) == 0) begin
          hold      = 5;
          out_ready = 1'b0;
        end else begin
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    end

    initial begin : mon
      exp_t e;
      bit   held = 1'b0;
      bit   have_e = 1'b0;
      bit   rst_seen = 1'b0;
      forever begin
        @(negedge clk);
        if (rst_seen) begin
          chk(g, "rst_out_valid", out_valid, 0);
          chk(g, "rst_in_ready", in_ready, 1);
          chk(g, "rst_outputs", {out_bcd, out_neg, out_ovfl, out_ndig}, 0);
        end
        rst_seen = rst;
        if (rst) begin
          q.delete();
          held   = 1'b0;
          have_e = 1'b0;
        end else begin
          if (out_valid) begin
            if (!held) begin
              chk(g, "result_expected", longint'(q.size() > 0), 1);
              have_e = (q.size() > 0);
              if (have_e) begin
                e = q.pop_front();
                chk(g, "latency", cyc - e.acc, L + 1);
              end
            end
            if (have_e) begin
              chk(g, "neg", out_neg, e.neg);
              chk(g, "ovfl", out_ovfl, e.ovfl);
              chk(g, "ndig", out_ndig, e.ndig);
              if (!e.ovfl) chk(g, "bcd", out_bcd, e.bcd);
            end
            chk(g, "in_ready_busy", in_ready, 0);
            held = !out_ready;
          end else begin
            held = 1'b0;
          end
          if (in_valid && in_ready) q.push_back(model(in_data, cyc));
        end
      end
    end
  end

  initial begin : main
    bit all_done = 1'b0;
    for (int i = 0; i < 80000; i++) begin
      @(posedge clk);
      all_done = 1'b1;
      for (int k = 0; k < NCFG; k++) all_done = all_done & done[k];
      if (all_done) break;
    end
    chk(-1, "all_done", all_done, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
